// File: rtl/craft_enc_ctrl.sv
// CRAFT round sequencer: owns the 64-bit cipher state and steps the round index,
// the round-constant enable and the last-round flag around an external datapath.
module craft_enc_ctrl #(
  parameter int ROUNDS = 32,
  parameter int RIDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       pt,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [63:0]       ct,
  output logic [RIDX_W-1:0] r,
  output logic              rc_init,
  output logic              rc_ce,
  output logic              last_round,
  output logic [63:0]       dp_state,
  input  logic [63:0]       dp_next
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [RIDX_W-1:0] R_LAST = RIDX_W'(ROUNDS - 1);
  localparam logic [RIDX_W-1:0] R_ONE  = RIDX_W'(1);

  fsm_t        fsm;
  logic [63:0] st;

  // Status outputs are flops loaded with the decode of the next state, so they
  // never glitch and always agree with fsm/r in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      st         <= '0;
      ct         <= '0;
      r          <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rc_ce      <= 1'b0;
      last_round <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            fsm        <= RUN;
            st         <= pt;
            r          <= '0;
            ready      <= 1'b0;
            busy       <= 1'b1;
            rc_ce      <= 1'b1;
            last_round <= 1'b0;
          end
        end
        RUN: begin
          st <= dp_next;
          if (r == R_LAST) begin
            fsm        <= DONE;
            ct         <= dp_next;
            r          <= '0;
            done       <= 1'b1;
            rc_ce      <= 1'b0;
            last_round <= 1'b0;
          end else begin
            r          <= r + R_ONE;
            last_round <= ((r + R_ONE) == R_LAST);
          end
        end
        DONE: begin
          fsm   <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          fsm        <= IDLE;
          r          <= '0;
          ready      <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
          rc_ce      <= 1'b0;
          last_round <= 1'b0;
        end
      endcase
    end
  end

  // Re-seed the constant generator on the same edge that accepts the block.
  assign rc_init  = ready & start;
  assign dp_state = st;

endmodule

// File: tb/tb_craft_enc_ctrl.sv
// Scoreboard bench for craft_enc_ctrl with a stub round datapath and a
// round-by-round reference model of the cipher state.
module tb_craft_enc_ctrl;
  localparam int ROUNDS = 32;
  localparam int RW     = 8;

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic [63:0]   pt, ct, dp_state, dp_next;
  logic          ready, busy, done, rc_init, rc_ce, last_round;
  logic [RW-1:0] r;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  craft_enc_ctrl #(.ROUNDS(ROUNDS), .RIDX_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .pt(pt), .ready(ready), .busy(busy),
    .done(done), .ct(ct), .r(r), .rc_init(rc_init), .rc_ce(rc_ce),
    .last_round(last_round), .dp_state(dp_state), .dp_next(dp_next)
  );

  always #5 clk = ~clk;

  // Stub round function: mode 0 is the plain "state + round" stub, mode 1 mixes harder.
  function automatic logic [63:0] stub_f(input logic [63:0] s, input int k, input logic m);
    logic [63:0] kk;
    kk = 64'(k);
    if (m) return ({s[62:0], s[63]} ^ kk) + 64'h9E3779B97F4A7C15;
    return s + kk;
  endfunction

  function automatic logic [63:0] model_ct(input logic [63:0] p, input logic m);
    logic [63:0] s;
    s = p;
    for (int k = 0; k < ROUNDS; k++) s = stub_f(s, k, m);
    return s;
  endfunction

  always_comb dp_next = stub_f(dp_state, int'(r), mode);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue side: every accepting edge pushes the expected ciphertext.
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (ready && start) exp_q.push_back(model_ct(pt, mode));
  end

  // Monitor: k = cycles since the accepting edge (0 = idle).
  int          k = 0;
  logic [63:0] ms = '0;
  logic [63:0] last_ct = '0;
  logic [63:0] e;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_r", r, 0); chk("rst_ct", ct, 0); chk("rst_rc_ce", rc_ce, 0);
      chk("rst_last", last_round, 0); chk("rst_state", dp_state, 0);
      k = 0;
      last_ct = '0;
    end else begin
      chk("ready", ready, k == 0);
      chk("busy", busy, k != 0);
      chk("done", done, k == ROUNDS + 1);
      chk("rc_ce", rc_ce, k >= 1 && k <= ROUNDS);
      chk("last_round", last_round, k == ROUNDS);
      chk("rc_init", rc_init, k == 0 && start);
      chk("r", r, 64'((k >= 1 && k <= ROUNDS) ? k - 1 : 0));
      if (k >= 1 && k <= ROUNDS) begin
        chk("dp_state", dp_state, ms);
        ms = stub_f(ms, k - 1, mode);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: done with ct %h but nothing expected", ct);
        end else begin
          e = exp_q.pop_front();
          chk("ct", ct, e);
          last_ct = e;
        end
      end else begin
        chk("ct_hold", ct, last_ct);
      end
      if (k == 0) begin
        if (start) begin
          k = 1;
          ms = pt;
        end
      end else if (k == ROUNDS + 1) k = 0;
      else k++;
    end
  end

  // All stimulus tasks return at posedge+1.
  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = ready && start;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout: start not accepted in 100 cycles");
    end
  endtask

  task automatic wait_done(input logic noise, output logic [63:0] c);
    logic got;
    got = 1'b0;
    c = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (noise) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        c = ct;
      end
    end
    @(posedge clk); #1;
    if (!got) begin
      checks++; failures++;
      $display("FAIL done_timeout: no done in 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [63:0] c, pv;
  initial begin
    rst = 1'b1; start = 1'b0; pt = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_ready", ready, 1); chk("init_busy", busy, 0); chk("init_ct", ct, 0);
    chk("init_r", r, 0); chk("init_done", done, 0);
    rst = 1'b0;
    idle(2);

    // Single pulse, pt=0
    pt = '0; start = 1'b1;
    wait_accept();
    start = 1'b0; pt = 64'hFFFF_FFFF_FFFF_FFFF;
    wait_done(1'b0, c);
    chk("ct_pt0", c, 64'h0000_0000_0000_01F0);
    idle(3);

    // Back-to-back with start held, pt switched right after acceptance
    pt = '0; start = 1'b1;
    wait_accept();
    pt = 64'h1;
    wait_done(1'b0, c);
    chk("ct_b2b0", c, 64'h1F0);
    wait_accept();
    start = 1'b0; pt = {$urandom, $urandom};
    wait_done(1'b0, c);
    chk("ct_b2b1", c, 64'h1F1);
    idle(2);

    // start held continuously while pt churns every cycle
    start = 1'b1;
    repeat (5 * (ROUNDS + 2)) begin
      @(posedge clk); #1;
      pt = {$urandom, $urandom};
    end
    idle(ROUNDS + 4);

    // Asynchronous reset in the r=17 round
    pt = {$urandom, $urandom}; start = 1'b1;
    wait_accept();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (r == RW'(17)) break;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", ready, 1); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    chk("arst_r", r, 0); chk("arst_ct", ct, 0); chk("arst_rc_ce", rc_ce, 0);
    chk("arst_last", last_round, 0);
    mode = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    pv = {$urandom, $urandom};
    pt = pv; start = 1'b1;
    wait_accept();
    start = 1'b0;
    wait_done(1'b0, c);
    chk("ct_after_rst", c, model_ct(pv, 1'b1));

    // Randomised traffic with start noise during busy
    repeat (20) begin
      idle($urandom_range(0, 3));
      pt = {$urandom, $urandom}; start = 1'b1;
      wait_accept();
      start = 1'b0;
      wait_done(1'($urandom_range(0, 1)), c);
    end
    idle(2 * ROUNDS + 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
